// File: rtl/score_tracker_if.sv
// Bundle between the arrow droppers / keyboard side and the score tracker.
// The master drives key and dropper flags; the slave returns score and game status.
interface score_tracker_if #(
  parameter int NUM_NOTES = 32
);
  logic [7:0]           keycode;
  logic [NUM_NOTES-1:0] hit_vec;
  logic [NUM_NOTES-1:0] miss_vec;
  logic [15:0]          score;
  logic [7:0]           combo;
  logic [7:0]           max_combo;
  logic [7:0]           hit_cnt;
  logic [7:0]           miss_cnt;
  logic                 playing;
  logic                 song_done;

  modport master (
    output keycode, hit_vec, miss_vec,
    input  score, combo, max_combo, hit_cnt, miss_cnt, playing, song_done
  );

  modport slave (
    input  keycode, hit_vec, miss_vec,
    output score, combo, max_combo, hit_cnt, miss_cnt, playing, song_done
  );
endinterface

// File: rtl/score_tracker.sv
// Turns dropper hit/miss level flags into events and keeps score, combo and counts for one song.
// One frame_clk of latency from a rising flag to updated outputs; no backpressure (events are never lost).
module score_tracker #(
  parameter int         NUM_NOTES   = 32,
  parameter int         HIT_PTS     = 10,
  parameter int         COMBO_X2    = 10,
  parameter logic [7:0] KEY_START   = 8'h2c,
  parameter logic [7:0] KEY_RESTART = 8'h01
) (
  input logic            frame_clk,
  input logic            Reset,
  score_tracker_if.slave trk
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAYING = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t               state_q;
  logic [NUM_NOTES-1:0] hit_prev_q, miss_prev_q;
  logic [15:0]          score_q;
  logic [7:0]           combo_q, max_combo_q, hit_cnt_q, miss_cnt_q;
  logic                 playing_q, song_done_q;

  logic [NUM_NOTES-1:0] hit_ev, miss_ev;
  logic [15:0]          nh, nm;
  logic [7:0]           run;
  logic [23:0]          pts_sum, score_sum;
  logic [15:0]          hit_sum, miss_sum;
  logic [15:0]          score_d;
  logic [7:0]           combo_d, max_combo_d, hit_cnt_d, miss_cnt_d;
  logic                 done_d;

  // Hits are walked first so each one sees the combo built by the hits before it.
  always_comb begin
    hit_ev  = trk.hit_vec & ~hit_prev_q;
    miss_ev = trk.miss_vec & ~miss_prev_q & ~hit_ev;
    run     = combo_q;
    pts_sum = '0;
    nh      = '0;
    nm      = '0;
    for (int i = 0; i < NUM_NOTES; i++) begin
      if (hit_ev[i]) begin
        pts_sum = pts_sum + ((int'(run) >= COMBO_X2) ? 24'(2 * HIT_PTS) : 24'(HIT_PTS));
        if (run != 8'hFF) run = run + 8'd1;
        nh = nh + 16'd1;
      end
      if (miss_ev[i]) nm = nm + 16'd1;
    end

    score_sum   = 24'(score_q) + pts_sum;
    score_d     = (score_sum > 24'h00FFFF) ? 16'hFFFF : score_sum[15:0];
    hit_sum     = 16'(hit_cnt_q) + nh;
    miss_sum    = 16'(miss_cnt_q) + nm;
    hit_cnt_d   = (hit_sum > 16'd255) ? 8'hFF : hit_sum[7:0];
    miss_cnt_d  = (miss_sum > 16'd255) ? 8'hFF : miss_sum[7:0];
    combo_d     = (nm != 16'd0) ? 8'd0 : run;
    max_combo_d = (run > max_combo_q) ? run : max_combo_q;
    done_d      = (int'(hit_cnt_d) + int'(miss_cnt_d)) >= NUM_NOTES;
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      hit_prev_q  <= '0;
      miss_prev_q <= '0;
      score_q     <= '0;
      combo_q     <= '0;
      max_combo_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      playing_q   <= 1'b0;
      song_done_q <= 1'b0;
    end else begin
      // Edge registers track the levels in every state so stale flags never fire later.
      hit_prev_q  <= trk.hit_vec;
      miss_prev_q <= trk.miss_vec;
      case (state_q)
        ST_IDLE: begin
          if (trk.keycode == KEY_START) begin
            state_q   <= ST_PLAYING;
            playing_q <= 1'b1;
          end
        end
        ST_PLAYING: begin
          score_q     <= score_d;
          combo_q     <= combo_d;
          max_combo_q <= max_combo_d;
          hit_cnt_q   <= hit_cnt_d;
          miss_cnt_q  <= miss_cnt_d;
          if (done_d) begin
            state_q     <= ST_DONE;
            playing_q   <= 1'b0;
            song_done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (trk.keycode == KEY_RESTART) begin
            state_q     <= ST_IDLE;
            song_done_q <= 1'b0;
            score_q     <= '0;
            combo_q     <= '0;
            max_combo_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          playing_q   <= 1'b0;
          song_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign trk.score     = score_q;
  assign trk.combo     = combo_q;
  assign trk.max_combo = max_combo_q;
  assign trk.hit_cnt   = hit_cnt_q;
  assign trk.miss_cnt  = miss_cnt_q;
  assign trk.playing   = playing_q;
  assign trk.song_done = song_done_q;

endmodule
